// File: rtl/collatz_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : collatz_pkg
//  Description : Shared constants and types for the collatz Wishbone
//                front-end: register word offsets, CTRL/STATUS bit indices,
//                controller FSM encoding and the core seed width.
//  Revision    : 1.0  initial release
// ============================================================================
package collatz_pkg;

    localparam int SEED_W = 16;

    // Register word offsets (byte address bits [7:2])
    localparam logic [5:0] OFF_CTRL   = 6'h00;
    localparam logic [5:0] OFF_SEED   = 6'h01;
    localparam logic [5:0] OFF_STATUS = 6'h02;
    localparam logic [5:0] OFF_STEPS  = 6'h03;
    localparam logic [5:0] OFF_PEAK   = 6'h04;
    localparam logic [5:0] OFF_LAST   = 6'h05;

    // CTRL bit indices
    localparam int CTRL_START  = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_CLR    = 2;

    // STATUS bit indices
    localparam int SB_BUSY     = 0;
    localparam int SB_DONE     = 1;
    localparam int SB_ERR_SEED = 2;
    localparam int SB_ERR_BUSY = 3;
    localparam int SB_ERR_TMO  = 4;
    localparam int SB_STEP_SAT = 5;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_RUN    = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/collatz_wb_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : collatz_wb_ctrl_if
//  Description : Wishbone-classic slave bus bundle for the collatz front-end.
//                Signal names are from the slave's point of view.
//  Ports       : wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i[3:0],
//                wbs_dat_i[31:0], wbs_adr_i[31:0]  (master -> slave)
//                wbs_ack_o, wbs_dat_o[31:0]        (slave -> master)
//  Revision    : 1.0  initial release
// ============================================================================
interface collatz_wb_ctrl_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface
`default_nettype wire

// File: rtl/collatz_wb_regif.sv
`default_nettype none
// ============================================================================
//  Module      : collatz_wb_regif
//  Description : Address decode, single-cycle registered ack and readback mux
//                for the collatz register block. Emits one-cycle write
//                strobes for CTRL and SEED; other writes are dropped.
//  Ports       : wb_clk_i, wb_rst_i (async, active-high), wbs (slave bus),
//                ctrl_wr_o/seed_wr_o write strobes, wr_dat_o/wr_sel_o write
//                payload, *_rd_i readback values from the controller.
//  Revision    : 1.0  initial release
// ============================================================================
module collatz_wb_regif
    import collatz_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  wire logic         wb_clk_i,
    input  wire logic         wb_rst_i,
    collatz_wb_ctrl_if.slave  wbs,
    output logic              ctrl_wr_o,
    output logic              seed_wr_o,
    output logic [31:0]       wr_dat_o,
    output logic [3:0]        wr_sel_o,
    input  wire logic [31:0]  ctrl_rd_i,
    input  wire logic [31:0]  seed_rd_i,
    input  wire logic [31:0]  status_rd_i,
    input  wire logic [31:0]  steps_rd_i,
    input  wire logic [31:0]  peak_rd_i,
    input  wire logic [31:0]  last_rd_i
);

    logic        w_hit;
    logic        w_acc;
    logic [5:0]  w_off;
    logic [31:0] w_rdata;
    logic        ack_q;
    logic [31:0] dat_q;
    logic        w_unused_ok;

    assign w_hit = wbs.wbs_stb_i & wbs.wbs_cyc_i &
                   (wbs.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    // An access is taken only when ack is low, so the cycle after an ack
    // never re-accepts the still-asserted strobe.
    assign w_acc = w_hit & ~ack_q;
    assign w_off = wbs.wbs_adr_i[7:2];

    assign ctrl_wr_o = w_acc & wbs.wbs_we_i & (w_off == OFF_CTRL);
    assign seed_wr_o = w_acc & wbs.wbs_we_i & (w_off == OFF_SEED);
    assign wr_dat_o  = wbs.wbs_dat_i;
    assign wr_sel_o  = wbs.wbs_sel_i;

    always_comb begin
        w_rdata = '0;
        case (w_off)
            OFF_CTRL:   w_rdata = ctrl_rd_i;
            OFF_SEED:   w_rdata = seed_rd_i;
            OFF_STATUS: w_rdata = status_rd_i;
            OFF_STEPS:  w_rdata = steps_rd_i;
            OFF_PEAK:   w_rdata = peak_rd_i;
            OFF_LAST:   w_rdata = last_rd_i;
            default:    w_rdata = '0;
        endcase
    end

    // Read data is registered alongside ack and is zero whenever ack is low.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= w_acc;
            dat_q <= (w_acc & ~wbs.wbs_we_i) ? w_rdata : '0;
        end
    end

    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_dat_o = dat_q;

    assign w_unused_ok = ^wbs.wbs_adr_i[1:0];

endmodule
`default_nettype wire

// File: rtl/collatz_wb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : collatz_wb_ctrl
//  Description : Wishbone-classic front-end for the collatz core. Latches the
//                seed, issues a one-cycle start pulse, then tracks core busy
//                and value to record step count, peak and final value.
//  Ports       : wb_clk_i, wb_rst_i (async, active-high), wbs (slave bus),
//                core_co[15:0] seed out, core_st start pulse, core_x[15:0]
//                core value in, core_bs core busy in, irq done interrupt.
//  Options     : COLLATZ_IRQ_EN - when defined, CTRL bit1 (IRQ_EN) is a
//                real register and irq = DONE & IRQ_EN; otherwise irq = 0.
//  Revision    : 1.0  initial release
// ============================================================================
module collatz_wb_ctrl
    import collatz_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
    parameter int          STEP_W       = 24,
    parameter int          WAIT_TIMEOUT = 8
) (
    input  wire logic              wb_clk_i,
    input  wire logic              wb_rst_i,
    collatz_wb_ctrl_if.slave       wbs,
    output logic [SEED_W-1:0]      core_co,
    output logic                   core_st,
    input  wire logic [SEED_W-1:0] core_x,
    input  wire logic              core_bs,
    output logic                   irq
);

    localparam int TMO_W = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] C_TMO_LAST = TMO_W'(WAIT_TIMEOUT - 1);

    state_t              state_q, state_d;
    logic [SEED_W-1:0]   seed_q, seed_d;
    logic [SEED_W-1:0]   co_q, co_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [STEP_W-1:0]   steps_q, steps_d;
    logic [SEED_W-1:0]   peak_q, peak_d;
    logic [SEED_W-1:0]   last_q, last_d;
    logic                done_q, done_d;
    logic                err_seed_q, err_seed_d;
    logic                err_busy_q, err_busy_d;
    logic                err_tmo_q, err_tmo_d;
    logic                sat_q, sat_d;

    logic                w_ctrl_wr;
    logic                w_seed_wr;
    logic [31:0]         w_wr_dat;
    logic [3:0]          w_wr_sel;
    logic                w_start;
    logic                w_clr;
    logic                w_count;
    logic                w_irq_en;
    logic [31:0]         w_status;
    logic                w_unused_ok;

    collatz_wb_regif #(
        .BASE_ADDR (BASE_ADDR)
    ) u_regif (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .wbs         (wbs),
        .ctrl_wr_o   (w_ctrl_wr),
        .seed_wr_o   (w_seed_wr),
        .wr_dat_o    (w_wr_dat),
        .wr_sel_o    (w_wr_sel),
        .ctrl_rd_i   ({30'd0, w_irq_en, 1'b0}),
        .seed_rd_i   (32'(seed_q)),
        .status_rd_i (w_status),
        .steps_rd_i  (32'(steps_q)),
        .peak_rd_i   (32'(peak_q)),
        .last_rd_i   (32'(last_q))
    );

    assign w_start = w_ctrl_wr & w_wr_sel[0] & w_wr_dat[CTRL_START];
    assign w_clr   = w_ctrl_wr & w_wr_sel[0] & w_wr_dat[CTRL_CLR];
    // The cycle that moves WAIT->RUN already has the core busy, so it is
    // counted as the first step of the run.
    assign w_count = core_bs & ((state_q == S_WAIT) | (state_q == S_RUN));

    always_comb begin
        w_status              = '0;
        w_status[SB_BUSY]     = (state_q != S_IDLE);
        w_status[SB_DONE]     = done_q;
        w_status[SB_ERR_SEED] = err_seed_q;
        w_status[SB_ERR_BUSY] = err_busy_q;
        w_status[SB_ERR_TMO]  = err_tmo_q;
        w_status[SB_STEP_SAT] = sat_q;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= S_IDLE;
            seed_q     <= '0;
            co_q       <= '0;
            tmo_q      <= '0;
            steps_q    <= '0;
            peak_q     <= '0;
            last_q     <= '0;
            done_q     <= 1'b0;
            err_seed_q <= 1'b0;
            err_busy_q <= 1'b0;
            err_tmo_q  <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            seed_q     <= seed_d;
            co_q       <= co_d;
            tmo_q      <= tmo_d;
            steps_q    <= steps_d;
            peak_q     <= peak_d;
            last_q     <= last_d;
            done_q     <= done_d;
            err_seed_q <= err_seed_d;
            err_busy_q <= err_busy_d;
            err_tmo_q  <= err_tmo_d;
            sat_q      <= sat_d;
        end
    end

    // Ordering inside this block matters: CLR is applied first so that any
    // flag set later in the same cycle (START error, completion) wins.
    always_comb begin
        state_d    = state_q;
        seed_d     = seed_q;
        co_d       = co_q;
        tmo_d      = tmo_q;
        steps_d    = steps_q;
        peak_d     = peak_q;
        last_d     = last_q;
        done_d     = done_q;
        err_seed_d = err_seed_q;
        err_busy_d = err_busy_q;
        err_tmo_d  = err_tmo_q;
        sat_d      = sat_q;

        if (w_seed_wr) begin
            if (w_wr_sel[0]) seed_d[7:0]  = w_wr_dat[7:0];
            if (w_wr_sel[1]) seed_d[15:8] = w_wr_dat[15:8];
        end

        if (w_clr) begin
            done_d     = 1'b0;
            err_seed_d = 1'b0;
            err_busy_d = 1'b0;
            err_tmo_d  = 1'b0;
        end

        if (w_start && (state_q != S_IDLE)) begin
            err_busy_d = 1'b1;
        end

        if (w_count) begin
            if (&steps_q) begin
                sat_d = 1'b1;
            end else begin
                steps_d = steps_q + 1'b1;
            end
            if (core_x > peak_q) begin
                peak_d = core_x;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (w_start) begin
                    if (seed_q == '0) begin
                        err_seed_d = 1'b1;
                    end else begin
                        state_d = S_LAUNCH;
                        co_d    = seed_q;
                        peak_d  = seed_q;
                        steps_d = '0;
                        done_d  = 1'b0;
                        sat_d   = 1'b0;
                    end
                end
            end
            S_LAUNCH: begin
                state_d = S_WAIT;
                tmo_d   = '0;
            end
            S_WAIT: begin
                if (core_bs) begin
                    state_d = S_RUN;
                end else if (tmo_q == C_TMO_LAST) begin
                    err_tmo_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_RUN: begin
                if (!core_bs) begin
                    last_d  = core_x;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign core_co = co_q;
    assign core_st = (state_q == S_LAUNCH);

`ifdef COLLATZ_IRQ_EN
    logic irq_en_q;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            irq_en_q <= 1'b0;
        end else if (w_ctrl_wr && w_wr_sel[0]) begin
            irq_en_q <= w_wr_dat[CTRL_IRQ_EN];
        end
    end

    assign w_irq_en = irq_en_q;
    assign irq      = done_q & irq_en_q;
`else
    assign w_irq_en = 1'b0;
    assign irq      = 1'b0;
`endif

    assign w_unused_ok = ^{w_wr_dat[31:16], w_wr_sel[3:2]};

endmodule
`default_nettype wire

// File: tb/tb_collatz_wb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_collatz_wb_ctrl
//  Description : Self-checking bench for collatz_wb_ctrl. Bus reads push the
//                expected value into a scoreboard queue; a monitor pops and
//                compares on every read ack. A small behavioural collatz
//                core responds to the start pulse. Expectations for the
//                COLLATZ_IRQ_EN option follow the build macro.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_collatz_wb_ctrl;

    localparam logic [31:0] C_BASE   = 32'h3000_0000;
    localparam logic [31:0] A_CTRL   = C_BASE + 32'h00;
    localparam logic [31:0] A_SEED   = C_BASE + 32'h04;
    localparam logic [31:0] A_STATUS = C_BASE + 32'h08;
    localparam logic [31:0] A_STEPS  = C_BASE + 32'h0C;
    localparam logic [31:0] A_PEAK   = C_BASE + 32'h10;
    localparam logic [31:0] A_LAST   = C_BASE + 32'h14;
    localparam logic [31:0] A_UNMAP  = C_BASE + 32'h20;

`ifdef COLLATZ_IRQ_EN
    localparam logic        C_IRQ_ON = 1'b1;
`else
    localparam logic        C_IRQ_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] core_co;
    logic        core_st;
    logic [15:0] core_x;
    logic        core_bs;
    logic        irq;
    logic        nobs;

    int          errors = 0;
    int          checks = 0;
    int          st_cnt = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];

    always #5 clk = ~clk;

    collatz_wb_ctrl_if bus ();

    collatz_wb_ctrl #(
        .BASE_ADDR    (C_BASE),
        .STEP_W       (24),
        .WAIT_TIMEOUT (8)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wbs      (bus),
        .core_co  (core_co),
        .core_st  (core_st),
        .core_x   (core_x),
        .core_bs  (core_bs),
        .irq      (irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Behavioural core: loads the seed on the start pulse, then walks the
    // collatz sequence one value per clock, dropping busy when it reaches 1.
    logic [15:0] m_nx;
    always @(posedge clk) begin
        if (core_st && !nobs) begin
            core_bs <= 1'b1;
            core_x  <= core_co;
        end else if (core_bs) begin
            m_nx = core_x[0] ? (core_x * 16'd3 + 16'd1) : (core_x >> 1);
            core_x <= m_nx;
            if (m_nx == 16'd1) core_bs <= 1'b0;
        end
    end

    always @(negedge clk) if (core_st) st_cnt++;

    // Scoreboard monitor
    always @(negedge clk) begin
        if (bus.wbs_ack_o && !bus.wbs_we_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read_ack: got 0x%08h expected no ack", bus.wbs_dat_o);
            end else begin
                check(name_q.pop_front(), bus.wbs_dat_o, exp_q.pop_front());
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output int lat, output logic got);
        bus.wbs_stb_i = 1'b1;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_adr_i = adr;
        bus.wbs_dat_i = dat;
        bus.wbs_sel_i = sel;
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            lat++;
            if (bus.wbs_ack_o) begin
                got = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_adr_i = '0;
        bus.wbs_dat_i = '0;
        bus.wbs_sel_i = '0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: got no ack expected ack for adr 0x%08h", adr);
        end
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel = 4'hF);
        int   lat;
        logic got;
        wb_xfer(1'b1, adr, dat, sel, lat, got);
    endtask

    task automatic wb_read(input logic [31:0] adr, input logic [31:0] exp, input string name,
                           output int lat);
        logic got;
        exp_q.push_back(exp);
        name_q.push_back(name);
        wb_xfer(1'b0, adr, 32'd0, 4'hF, lat, got);
        if (!got) begin
            void'(exp_q.pop_back());
            void'(name_q.pop_back());
        end
    endtask

    task automatic rd(input logic [31:0] adr, input logic [31:0] exp, input string name);
        int lat;
        wb_read(adr, exp, name, lat);
    endtask

    initial begin
        int lat;
        int st0;

        rst           = 1'b1;
        nobs          = 1'b0;
        core_bs       = 1'b0;
        core_x        = '0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_adr_i = '0;
        bus.wbs_dat_i = '0;
        bus.wbs_sel_i = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst_core_st", 32'(core_st), 32'd0);
        check("rst_core_co", 32'(core_co), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_ack", 32'(bus.wbs_ack_o), 32'd0);
        check("rst_dat_o", bus.wbs_dat_o, 32'd0);
        rd(A_STATUS, 32'h00, "rst_status");
        rd(A_STEPS, 32'd0, "rst_steps");

        // Seed 6: 6,3,10,5,16,8,4,2 busy then 1
        wb_write(A_SEED, 32'd6);
        rd(A_SEED, 32'd6, "seed_readback");
        st0 = st_cnt;
        wb_write(A_CTRL, 32'h1);
        cycles(20);
        check("run6_st_pulse", 32'(st_cnt - st0), 32'd1);
        check("run6_core_co", 32'(core_co), 32'd6);
        check("idle_dat_o", bus.wbs_dat_o, 32'd0);
        rd(A_STATUS, 32'h02, "run6_status");
        rd(A_STEPS, 32'd8, "run6_steps");
        rd(A_PEAK, 32'd16, "run6_peak");
        rd(A_LAST, 32'd1, "run6_last");

        // Zero seed
        wb_write(A_CTRL, 32'h4);
        rd(A_STATUS, 32'h00, "clr_status");
        wb_write(A_SEED, 32'd0);
        st0 = st_cnt;
        wb_write(A_CTRL, 32'h1);
        cycles(5);
        rd(A_STATUS, 32'h04, "seed0_status");
        check("seed0_no_st", 32'(st_cnt - st0), 32'd0);
        // CLR and START together: CLR first, then START re-flags the zero seed
        wb_write(A_CTRL, 32'h5);
        cycles(3);
        rd(A_STATUS, 32'h04, "clr_start_status");
        wb_write(A_CTRL, 32'h4);

        // START during a run. Seed 7: 16 busy values, peak 52
        wb_write(A_SEED, 32'd7);
        wb_write(A_CTRL, 32'h1);
        cycles(4);
        wb_write(A_CTRL, 32'h1);
        cycles(30);
        rd(A_STATUS, 32'h0A, "busy_status");
        rd(A_STEPS, 32'd16, "run7_steps");
        rd(A_PEAK, 32'd52, "run7_peak");
        rd(A_LAST, 32'd1, "run7_last");

        // Timeout: the core never goes busy
        wb_write(A_CTRL, 32'h4);
        nobs = 1'b1;
        wb_write(A_SEED, 32'd5);
        wb_write(A_CTRL, 32'h1);
        rd(A_STATUS, 32'h01, "tmo_busy");
        cycles(15);
        rd(A_STATUS, 32'h10, "tmo_status");
        nobs = 1'b0;

        // Asynchronous reset mid-run
        wb_write(A_CTRL, 32'h4);
        wb_write(A_SEED, 32'd7);
        wb_write(A_CTRL, 32'h1);
        cycles(6);
        check("pre_rst_core_co", 32'(core_co), 32'd7);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_core_st", 32'(core_st), 32'd0);
        check("arst_core_co", 32'(core_co), 32'd0);
        check("arst_irq", 32'(irq), 32'd0);
        check("arst_ack", 32'(bus.wbs_ack_o), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cycles(25);
        rd(A_STATUS, 32'h00, "arst_status");
        rd(A_STEPS, 32'd0, "arst_steps");
        rd(A_PEAK, 32'd0, "arst_peak");
        rd(A_LAST, 32'd0, "arst_last");
        rd(A_SEED, 32'd0, "arst_seed");
        wb_write(A_SEED, 32'd6);
        wb_write(A_CTRL, 32'h1);
        cycles(20);
        rd(A_STATUS, 32'h02, "rerun_status");
        rd(A_STEPS, 32'd8, "rerun_steps");
        rd(A_PEAK, 32'd16, "rerun_peak");

        // Interrupt enable (DONE is still set from the rerun)
        wb_write(A_CTRL, 32'h2);
        rd(A_CTRL, C_IRQ_ON ? 32'h2 : 32'h0, "ctrl_irq_en");
        check("irq_done", 32'(irq), 32'(C_IRQ_ON));
        wb_write(A_CTRL, 32'h6);
        check("irq_after_clr", 32'(irq), 32'd0);
        rd(A_STATUS, 32'h00, "irq_clr_status");
        wb_write(A_CTRL, 32'h3);
        cycles(20);
        check("irq_run", 32'(irq), 32'(C_IRQ_ON));
        rd(A_STATUS, 32'h02, "irq_run_status");
        wb_write(A_CTRL, 32'h4);
        check("irq_clr2", 32'(irq), 32'd0);

        // Unmapped offset, read-only write, byte enables
        wb_read(A_UNMAP, 32'd0, "unmapped_read", lat);
        check("unmapped_ack_lat", 32'(lat), 32'd2);
        wb_write(A_STATUS, 32'hFF);
        rd(A_STATUS, 32'h00, "status_ro");
        wb_write(A_SEED, 32'h1234, 4'b0001);
        rd(A_SEED, 32'h0034, "seed_sel0");
        wb_write(A_SEED, 32'hAB00, 4'b0010);
        rd(A_SEED, 32'hAB34, "seed_sel1");

        cycles(3);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
